tdc_result_packer: RTL and testbench



---
 rtl/tdc_result_packer_if.sv | 38 +++
 rtl/tdc_result_packer.sv | 181 ++++++++++++++++++
 tb/tb_tdc_result_packer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/tdc_result_packer_if.sv
// tdc_result_packer_if
// Bundles the measurement capture strobe and the outgoing byte stream of tdc_result_packer.
//   iValid     : one-cycle strobe, iTDC holds a new measurement
//   iTDC       : {coarse, start code, stop code}
//   oByte      : serialized record byte
//   oByteValid : oByte valid
//   iByteReady : sink accepts oByte
//   oLast      : final (4th) byte of a record
// slave is the packer's view; master is the view of whoever drives the capture strobe and sinks
// the bytes.
interface tdc_result_packer_if #(
  parameter int unsigned TDC_W = 24
) ();
  logic             iValid;
  logic [TDC_W-1:0] iTDC;
  logic [7:0]       oByte;
  logic             oByteValid;
  logic             iByteReady;
  logic             oLast;

  modport master (
    output iValid,
    output iTDC,
    output iByteReady,
    input  oByte,
    input  oByteValid,
    input  oLast
  );

  modport slave (
    input  iValid,
    input  iTDC,
    input  iByteReady,
    output oByte,
    output oByteValid,
    output oLast
  );
endinterface

// File: rtl/tdc_result_packer.sv
// tdc_result_packer
// Captures TDC measurement words, tags them {seq, err, ovf}, buffers them in a small FIFO and
// serializes each 32-bit record MSB byte first over a valid/ready byte stream.
//   iClk     : clock
//   rst      : synchronous active-high reset
//   bus      : capture strobe + byte stream (tdc_result_packer_if.slave)
//   oFull    : FIFO full
//   oEmpty   : FIFO empty
//   oLevel   : records held in FIFO (excludes the record being serialized)
//   oDropCnt : saturating count of dropped measurements
module tdc_result_packer #(
  parameter int unsigned COARSE_W   = 10,
  parameter int unsigned FINE_W     = 7,
  parameter int unsigned NUM_TAPS   = 120,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          iClk,
  input  logic                          rst,
  tdc_result_packer_if.slave            bus,
  output logic                          oFull,
  output logic                          oEmpty,
  output logic [$clog2(FIFO_DEPTH):0]   oLevel,
  output logic [7:0]                    oDropCnt
);

  localparam int unsigned TDC_W = COARSE_W + 2 * FINE_W;
  localparam int unsigned SEQ_W = 30 - TDC_W;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam logic [FINE_W:0] TAP_MAX = (FINE_W + 1)'(NUM_TAPS);

  typedef enum logic {StIdle, StSend} state_e;

  // Capture side
  logic [FINE_W-1:0] w_start;
  logic [FINE_W-1:0] w_stop;
  logic              w_err;
  logic [31:0]       w_rec;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;

  logic [SEQ_W-1:0]  r_seq;
  logic              r_drop_pend;
  logic [7:0]        r_drop_cnt;

  // FIFO
  logic [31:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic [LVL_W-1:0]  w_level_d;
  logic [31:0]       w_head;

  // Serializer
  state_e            r_state;
  state_e            w_state_d;
  logic [1:0]        r_idx;
  logic [1:0]        w_idx_d;
  logic [31:0]       r_shift;
  logic [31:0]       w_shift_d;

  assign w_start = bus.iTDC[2*FINE_W-1:FINE_W];
  assign w_stop  = bus.iTDC[FINE_W-1:0];
  assign w_err   = ({1'b0, w_start} > TAP_MAX) || ({1'b0, w_stop} > TAP_MAX);
  // ovf reports drops since the last written record, so it uses the flag before this capture.
  assign w_rec   = {r_seq, w_err, r_drop_pend, bus.iTDC};

  assign w_full  = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_empty = (r_level == '0);
  assign w_head  = r_mem[r_rd_ptr];

  // A full FIFO still accepts when the serializer pops on the same edge.
  assign w_push  = bus.iValid && !rst && (!w_full || w_pop);

  always_comb begin
    w_level_d = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_d = r_level + LVL_W'(1);
      2'b01:   w_level_d = r_level - LVL_W'(1);
      default: w_level_d = r_level;
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_shift_d = r_shift;
    w_pop     = 1'b0;
    case (r_state)
      StIdle: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_shift_d = w_head;
          w_idx_d   = 2'd0;
          w_state_d = StSend;
        end
      end
      StSend: begin
        if (bus.iByteReady) begin
          if (r_idx == 2'd3) begin
            // Chain straight into the next record to avoid a bubble.
            if (!w_empty) begin
              w_pop     = 1'b1;
              w_shift_d = w_head;
              w_idx_d   = 2'd0;
            end else begin
              w_state_d = StIdle;
            end
          end else begin
            w_idx_d = r_idx + 2'd1;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Storage has no reset; the pointers and level define what is valid.
  always_ff @(posedge iClk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_rec;
    end
  end

  always_ff @(posedge iClk) begin
    if (rst) begin
      r_seq       <= '0;
      r_drop_pend <= 1'b0;
      r_drop_cnt  <= 8'd0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_state     <= StIdle;
      r_idx       <= 2'd0;
      r_shift     <= 32'd0;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
      r_shift <= w_shift_d;
      r_level <= w_level_d;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (bus.iValid) begin
        // Counts every strobe so gaps in seq reveal drops.
        r_seq <= r_seq + SEQ_W'(1);
        if (w_push) begin
          r_drop_pend <= 1'b0;
        end else begin
          r_drop_pend <= 1'b1;
          if (r_drop_cnt != 8'hFF) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
          end
        end
      end
    end
  end

  always_comb begin
    bus.oByte = 8'd0;
    case (r_idx)
      2'd0:    bus.oByte = r_shift[31:24];
      2'd1:    bus.oByte = r_shift[23:16];
      2'd2:    bus.oByte = r_shift[15:8];
      default: bus.oByte = r_shift[7:0];
    endcase
  end

  assign bus.oByteValid = (r_state == StSend);
  assign bus.oLast      = (r_state == StSend) && (r_idx == 2'd3);
  assign oFull          = w_full;
  assign oEmpty         = w_empty;
  assign oLevel         = r_level;
  assign oDropCnt       = r_drop_cnt;

endmodule

// File: tb/tb_tdc_result_packer.sv
module tb_tdc_result_packer;
  localparam int unsigned COARSE_W   = 10;
  localparam int unsigned FINE_W     = 7;
  localparam int unsigned NUM_TAPS   = 120;
  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1;

  logic             iClk = 1'b0;
  logic             rst;
  logic             oFull;
  logic             oEmpty;
  logic [LVL_W-1:0] oLevel;
  logic [7:0]       oDropCnt;

  tdc_result_packer_if #(.TDC_W(COARSE_W + 2 * FINE_W)) bus ();

  tdc_result_packer #(
    .COARSE_W  (COARSE_W),
    .FINE_W    (FINE_W),
    .NUM_TAPS  (NUM_TAPS),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .iClk    (iClk),
    .rst     (rst),
    .bus     (bus),
    .oFull   (oFull),
    .oEmpty  (oEmpty),
    .oLevel  (oLevel),
    .oDropCnt(oDropCnt)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [23:0] tdc;
    logic [31:0] rec;
  } vec_t;

  vec_t vecs [6];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_rec(input int seq, input bit err, input bit ovf,
                                         input logic [23:0] tdc);
    return {6'(seq), err, ovf, tdc};
  endfunction

  // Ends on the falling edge just after the capture edge.
  task automatic strobe(input logic [23:0] tdc);
    @(negedge iClk);
    bus.iValid = 1'b1;
    bus.iTDC   = tdc;
    @(negedge iClk);
    bus.iValid = 1'b0;
  endtask

  // Called on a falling edge with ready high; consumes one record.
  task automatic recv(input logic [31:0] exp, input string name, input int exp_wait);
    int waited = 0;
    while (!bus.oByteValid && waited < 40) begin
      @(negedge iClk);
      waited++;
    end
    if (exp_wait >= 0) check({name, " wait"}, 32'(waited), 32'(exp_wait));
    check({name, " valid"}, 32'(bus.oByteValid), 32'd1);
    if (!bus.oByteValid) return;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s b%0d valid", name, k), 32'(bus.oByteValid), 32'd1);
      check($sformatf("%s b%0d", name, k), 32'(bus.oByte), 32'(exp[31-8*k -: 8]));
      check($sformatf("%s b%0d last", name, k), 32'(bus.oLast), (k == 3) ? 32'd1 : 32'd0);
      @(negedge iClk);
    end
  endtask

  initial begin
    vecs[0] = '{tdc: 24'h554905, rec: 32'h00554905};  // coarse 0x155 start 0x12 stop 0x05
    vecs[1] = '{tdc: 24'h003C80, rec: 32'h06003C80};  // start 121 -> err
    vecs[2] = '{tdc: 24'h003C00, rec: 32'h08003C00};  // start 120 -> no err
    vecs[3] = '{tdc: 24'hFFC079, rec: 32'h0EFFC079};  // stop 121 -> err
    vecs[4] = '{tdc: 24'hAABFFF, rec: 32'h12AABFFF};  // both 127 -> err
    vecs[5] = '{tdc: 24'h007C78, rec: 32'h14007C78};  // both 120 -> no err

    bus.iValid     = 1'b0;
    bus.iTDC       = '0;
    bus.iByteReady = 1'b1;
    rst            = 1'b1;
    repeat (3) @(negedge iClk);
    check("rst oByte", 32'(bus.oByte), 32'd0);
    check("rst oByteValid", 32'(bus.oByteValid), 32'd0);
    check("rst oLast", 32'(bus.oLast), 32'd0);
    check("rst oFull", 32'(oFull), 32'd0);
    check("rst oEmpty", 32'(oEmpty), 32'd1);
    check("rst oLevel", 32'(oLevel), 32'd0);
    check("rst oDropCnt", 32'(oDropCnt), 32'd0);
    rst = 1'b0;

    // Table vectors, seq 0..5; valid rises one edge after capture.
    for (int i = 0; i < 6; i++) begin
      strobe(vecs[i].tdc);
      recv(vecs[i].rec, $sformatf("vec%0d", i), 1);
      check($sformatf("vec%0d empty", i), 32'(oEmpty), 32'd1);
    end

    // Backpressure, seq 6: start code 121 -> err.
    bus.iByteReady = 1'b0;
    strobe(24'h0ABCDE);
    @(negedge iClk);
    for (int c = 0; c < 10; c++) begin
      check("bp hold valid", 32'(bus.oByteValid), 32'd1);
      check("bp hold byte", 32'(bus.oByte), 32'h1A);
      check("bp hold last", 32'(bus.oLast), 32'd0);
      @(negedge iClk);
    end
    bus.iByteReady = 1'b1;
    recv(32'h1A0ABCDE, "bp", 0);

    // Seq wrap: 7..63 then 64 wraps to 0.
    for (int s = 7; s <= 64; s++) begin
      strobe(24'(s));
      recv(mk_rec(s, 1'b0, 1'b0, 24'(s)), $sformatf("seq%0d", s), 1);
    end

    // Overflow from a fresh reset. The head record moves into the output register on the edge
    // after its capture, so 16 FIFO slots plus that one accept 17 of the 20 strobes.
    @(negedge iClk);
    rst = 1'b1;
    @(negedge iClk);
    rst = 1'b0;
    bus.iByteReady = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.iValid = 1'b1;
      bus.iTDC   = 24'(i);
      @(negedge iClk);
      if (i == 15) check("ovf not full at 15", 32'(oFull), 32'd0);
      if (i == 16) check("ovf full", 32'(oFull), 32'd1);
    end
    bus.iValid = 1'b0;
    check("ovf level", 32'(oLevel), 32'd16);
    check("ovf full hold", 32'(oFull), 32'd1);
    check("ovf dropcnt", 32'(oDropCnt), 32'd3);
    bus.iByteReady = 1'b1;
    for (int s = 0; s <= 16; s++) begin
      recv(mk_rec(s, 1'b0, 1'b0, 24'(s)), $sformatf("ovf rec%0d", s), 0);
    end
    check("ovf drained", 32'(oEmpty), 32'd1);
    strobe(24'h000042);
    recv(32'h51000042, "ovf flag", 1);
    strobe(24'h000043);
    recv(32'h54000043, "ovf cleared", 1);

    // Back-to-back, seq 22..24.
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge iClk);
          bus.iValid = 1'b1;
          bus.iTDC   = 24'h000A00 + 24'(k);
        end
        @(negedge iClk);
        bus.iValid = 1'b0;
      end
      begin
        recv(mk_rec(22, 1'b0, 1'b0, 24'h000A00), "b2b0", -1);
        recv(mk_rec(23, 1'b0, 1'b0, 24'h000A01), "b2b1", 0);
        recv(mk_rec(24, 1'b0, 1'b0, 24'h000A02), "b2b2", 0);
      end
    join
    check("b2b empty", 32'(oEmpty), 32'd1);
    check("b2b idle", 32'(bus.oByteValid), 32'd0);

    // Reset mid-record: seq 25 in flight at byte 2, five records queued.
    bus.iByteReady = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge iClk);
      bus.iValid = 1'b1;
      bus.iTDC   = 24'h000100 + 24'(k);
    end
    @(negedge iClk);
    bus.iValid = 1'b0;
    check("mid level", 32'(oLevel), 32'd5);
    bus.iByteReady = 1'b1;
    @(negedge iClk);
    @(negedge iClk);
    check("mid idx2 byte", 32'(bus.oByte), 32'h01);
    rst        = 1'b1;
    bus.iValid = 1'b1;
    bus.iTDC   = 24'h000077;
    @(negedge iClk);
    rst        = 1'b0;
    bus.iValid = 1'b0;
    check("mid rst valid", 32'(bus.oByteValid), 32'd0);
    check("mid rst level", 32'(oLevel), 32'd0);
    check("mid rst dropcnt", 32'(oDropCnt), 32'd0);
    check("mid rst empty", 32'(oEmpty), 32'd1);
    @(negedge iClk);
    check("mid rst ignored valid", 32'(bus.oByteValid), 32'd0);
    check("mid rst ignored level", 32'(oLevel), 32'd0);
    strobe(24'h000123);
    recv(32'h00000123, "post rst", 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
